// File: rtl/token_ring_pkg.sv
// Shared constants for the token ring Petri-net block.
// Holds the default ring size, the default initial marking and the
// encodings of the CONCURRENT firing-mode parameter.
package token_ring_pkg;

  // Default number of places / transitions in the ring.
  localparam int DEFAULT_N = 10;

  // Default initial marking: one token in each of places 0, 1 and 2.
  localparam logic [DEFAULT_N-1:0] DEFAULT_INIT_MARKING = 10'b0000000111;

  // CONCURRENT parameter encodings.
  localparam int CONCURRENT_LOWEST = 0;  // only the lowest-index enabled transition fires
  localparam int CONCURRENT_ALL    = 1;  // every enabled transition fires in the same cycle

endpackage

// File: rtl/token_ring_fsm_popcount.sv
// Combinational population counter.
// Ports:
//   bits  - input vector of W bits
//   count - number of set bits in 'bits', $clog2(W+1) bits wide
module popcount #(
  parameter int W = 8
) (
  input  logic [W-1:0]           bits,
  output logic [$clog2(W+1)-1:0] count
);

  localparam int CW = $clog2(W+1);

  // Ripple sum of the individual bits.
  always_comb begin
    count = {CW{1'b0}};
    for (int i = 0; i < W; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/token_ring_fsm.sv
// Ring-shaped Petri net: N places, N transitions, transition ti moves a
// token from place i to place (i+1) mod N.
// Ports:
//   clk     - rising-edge clock
//   reset   - synchronous active-high reset (marking <= INIT_MARKING, err <= 0)
//   en      - global firing enable; 0 freezes the marking and err
//   t_req   - bit i requests transition ti
//   fire    - same-cycle indication that ti fires at the next edge
//   blocked - bit i: request present, token present, successor place full
//   marking - current place register
//   tokens  - population count of marking
//   err     - sticky flag, set when an enabled request targets an empty place
module token_ring_fsm
  import token_ring_pkg::*;
#(
  parameter int             N            = DEFAULT_N,
  parameter logic [N-1:0]   INIT_MARKING = N'(DEFAULT_INIT_MARKING),
  parameter int             CONCURRENT   = CONCURRENT_ALL
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [N-1:0]           t_req,
  output logic [N-1:0]           fire,
  output logic [N-1:0]           blocked,
  output logic [N-1:0]           marking,
  output logic [$clog2(N+1)-1:0] tokens,
  output logic                   err
);

  logic [N-1:0] marking_r;
  logic         err_r;
  logic [N-1:0] marking_next_s;
  logic         err_next_s;
  logic [N-1:0] succ_s;       // succ_s[i] = marking of place (i+1) mod N
  logic [N-1:0] enabled_s;
  logic [N-1:0] lowest_s;
  logic [N-1:0] fire_s;
  logic [N-1:0] pred_fire_s;  // pred_fire_s[i] = fire of transition (i-1) mod N
  logic         illegal_s;

  // Next-state, firing and status decode from the start-of-cycle marking.
  always_comb begin
    succ_s         = {marking_r[0], marking_r[N-1:1]};
    enabled_s      = {N{en}} & t_req & marking_r & ~succ_s;
    // Two's-complement trick isolates the lowest set bit (zero stays zero).
    lowest_s       = enabled_s & (~enabled_s + N'(1));
    fire_s         = {N{1'b0}};
    pred_fire_s    = {N{1'b0}};
    marking_next_s = marking_r;
    err_next_s     = err_r;
    illegal_s      = en & (|(t_req & ~marking_r));

    if (CONCURRENT != CONCURRENT_LOWEST) begin
      fire_s = enabled_s;
    end else begin
      fire_s = lowest_s;
    end

    pred_fire_s = {fire_s[N-2:0], fire_s[N-1]};
    // A receiving place was empty, so it cannot also be vacated this cycle.
    marking_next_s = (marking_r & ~fire_s) | pred_fire_s;

    if (illegal_s) begin
      err_next_s = 1'b1;
    end else begin
      err_next_s = err_r;
    end
  end

  // Single register bank: marking and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      marking_r <= INIT_MARKING;
      err_r     <= 1'b0;
    end else begin
      marking_r <= marking_next_s;
      err_r     <= err_next_s;
    end
  end

  popcount #(.W(N)) u_popcount (
    .bits  (marking_r),
    .count (tokens)
  );

  assign fire    = fire_s;
  assign blocked = t_req & marking_r & succ_s;
  assign marking = marking_r;
  assign err     = err_r;

endmodule

// File: tb/tb_token_ring_fsm.sv
// Scoreboard bench for token_ring_fsm. Four instances share the inputs and
// differ in INIT_MARKING / CONCURRENT; each expectation names the instance.
module tb_token_ring_fsm;

  localparam int NI = 4;

  logic       clk;
  logic       reset;
  logic       en;
  logic [9:0] t_req;

  logic [9:0] fire_w    [NI];
  logic [9:0] blocked_w [NI];
  logic [9:0] marking_w [NI];
  logic [3:0] tokens_w  [NI];
  logic       err_w     [NI];

  typedef struct {
    string      name;
    int         sel;
    bit   [4:0] chk;  // [0] fire [1] blocked [2] marking [3] tokens [4] err
    logic [9:0] fire;
    logic [9:0] blocked;
    logic [9:0] marking;
    logic [3:0] tokens;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  token_ring_fsm u_dflt (
    .clk(clk), .reset(reset), .en(en), .t_req(t_req),
    .fire(fire_w[0]), .blocked(blocked_w[0]), .marking(marking_w[0]),
    .tokens(tokens_w[0]), .err(err_w[0])
  );

  token_ring_fsm #(.N(10), .INIT_MARKING(10'h155), .CONCURRENT(1)) u_c1 (
    .clk(clk), .reset(reset), .en(en), .t_req(t_req),
    .fire(fire_w[1]), .blocked(blocked_w[1]), .marking(marking_w[1]),
    .tokens(tokens_w[1]), .err(err_w[1])
  );

  token_ring_fsm #(.N(10), .INIT_MARKING(10'h155), .CONCURRENT(0)) u_c0 (
    .clk(clk), .reset(reset), .en(en), .t_req(t_req),
    .fire(fire_w[2]), .blocked(blocked_w[2]), .marking(marking_w[2]),
    .tokens(tokens_w[2]), .err(err_w[2])
  );

  token_ring_fsm #(.N(10), .INIT_MARKING(10'h200), .CONCURRENT(1)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .t_req(t_req),
    .fire(fire_w[3]), .blocked(blocked_w[3]), .marking(marking_w[3]),
    .tokens(tokens_w[3]), .err(err_w[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string nm, input int sel, input bit [4:0] chk,
                      input logic [9:0] f, input logic [9:0] b, input logic [9:0] m,
                      input logic [3:0] t, input logic e);
    exp_t x;
    x.name = nm; x.sel = sel; x.chk = chk;
    x.fire = f; x.blocked = b; x.marking = m; x.tokens = t; x.err = e;
    sb_q.push_back(x);
  endtask

  task automatic cmp(input string nm, input string fld, input int sel,
                     input logic [9:0] got, input logic [9:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s.%s inst%0d: got 0x%03h expected 0x%03h", nm, fld, sel, got, want);
    end
  endtask

  // Monitor: outputs are stable at the falling edge; drain all expectations.
  always @(negedge clk) begin
    exp_t x;
    while (sb_q.size() != 0) begin
      x = sb_q.pop_front();
      if (x.chk[0]) cmp(x.name, "fire",    x.sel, fire_w[x.sel],    x.fire);
      if (x.chk[1]) cmp(x.name, "blocked", x.sel, blocked_w[x.sel], x.blocked);
      if (x.chk[2]) cmp(x.name, "marking", x.sel, marking_w[x.sel], x.marking);
      if (x.chk[3]) cmp(x.name, "tokens",  x.sel, {6'd0, tokens_w[x.sel]}, {6'd0, x.tokens});
      if (x.chk[4]) cmp(x.name, "err",     x.sel, {9'd0, err_w[x.sel]},    {9'd0, x.err});
    end
  end

  // Reference model, written per place rather than as vector algebra.
  function automatic logic [9:0] model_fire(logic [9:0] m, logic [9:0] req, logic e, bit conc);
    logic [9:0] f;
    f = 10'd0;
    if (e) begin
      for (int i = 0; i < 10; i++) begin
        if (req[i] && m[i] && !m[(i + 1) % 10]) begin
          if (conc || f == 10'd0) f[i] = 1'b1;
        end
      end
    end
    return f;
  endfunction

  function automatic logic [9:0] model_blocked(logic [9:0] m, logic [9:0] req);
    logic [9:0] b;
    b = 10'd0;
    for (int i = 0; i < 10; i++) b[i] = req[i] && m[i] && m[(i + 1) % 10];
    return b;
  endfunction

  function automatic logic [9:0] model_next(logic [9:0] m, logic [9:0] f);
    logic [9:0] n;
    n = m;
    for (int i = 0; i < 10; i++) begin
      if (f[i]) begin
        n[i] = 1'b0;
        n[(i + 1) % 10] = 1'b1;
      end
    end
    return n;
  endfunction

  initial begin
    logic [9:0] init_m [NI];
    bit         conc   [NI];
    logic [3:0] init_t [NI];
    logic [9:0] mm     [NI];
    logic       me     [NI];
    logic [9:0] f;

    init_m = '{10'h007, 10'h155, 10'h155, 10'h200};
    conc   = '{1'b1, 1'b1, 1'b0, 1'b1};
    init_t = '{4'd3, 4'd5, 4'd5, 4'd1};

    reset = 1'b1; en = 1'b0; t_req = 10'h000;
    step(); step();

    // Reset state with defaults.
    reset = 1'b0; en = 1'b1; t_req = 10'h000;
    push("reset_state", 0, 5'b11111, 10'h000, 10'h000, 10'h007, 4'd3, 1'b0);
    push("reset_state", 1, 5'b01100, 10'h000, 10'h000, 10'h155, 4'd5, 1'b0);
    push("reset_state", 3, 5'b11111, 10'h000, 10'h000, 10'h200, 4'd1, 1'b0);
    step();

    // en=0: no firing, but blocked still reported.
    en = 1'b0; t_req = 10'h3FF;
    push("en0_blocked", 0, 5'b11111, 10'h000, 10'h003, 10'h007, 4'd3, 1'b0);
    step();

    // All requests: default, concurrent 0x155, lowest-only 0x155.
    en = 1'b1; t_req = 10'h3FF;
    push("conc_007", 0, 5'b11111, 10'h004, 10'h003, 10'h007, 4'd3, 1'b0);
    push("conc_155", 1, 5'b11111, 10'h155, 10'h000, 10'h155, 4'd5, 1'b0);
    push("low_155",  2, 5'b11111, 10'h001, 10'h000, 10'h155, 4'd5, 1'b0);
    step();

    en = 1'b1; t_req = 10'h000;
    push("next_007", 0, 5'b11101, 10'h000, 10'h000, 10'h00B, 4'd3, 1'b1);
    push("next_155", 1, 5'b01101, 10'h000, 10'h000, 10'h2AA, 4'd5, 1'b0);
    push("next_low", 2, 5'b01101, 10'h000, 10'h000, 10'h156, 4'd5, 1'b0);
    reset = 1'b1;
    step();

    // Wrap-around and sticky error on the single-token instance.
    reset = 1'b0; en = 1'b1; t_req = 10'h200;
    push("wrap_fire", 3, 5'b11111, 10'h200, 10'h000, 10'h200, 4'd1, 1'b0);
    step();
    en = 1'b1; t_req = 10'h004;
    push("wrap_next", 3, 5'b11111, 10'h000, 10'h000, 10'h001, 4'd1, 1'b0);
    step();
    en = 1'b0; t_req = 10'h004;
    push("err_set", 3, 5'b10101, 10'h000, 10'h000, 10'h001, 4'd1, 1'b1);
    step();
    en = 1'b0; t_req = 10'h001;
    push("err_en0", 3, 5'b11111, 10'h000, 10'h000, 10'h001, 4'd1, 1'b1);
    step();
    en = 1'b1; t_req = 10'h001;
    push("err_hold", 3, 5'b10101, 10'h001, 10'h000, 10'h001, 4'd1, 1'b1);
    step();
    // Reset during a firing: fire still shown, register takes INIT.
    reset = 1'b1; en = 1'b1; t_req = 10'h002;
    push("rst_mid", 3, 5'b10101, 10'h002, 10'h000, 10'h002, 4'd1, 1'b1);
    step();
    reset = 1'b0; en = 1'b0; t_req = 10'h000;
    push("rst_clear", 3, 5'b11111, 10'h000, 10'h000, 10'h200, 4'd1, 1'b0);
    reset = 1'b1;
    step();

    // Random run against the reference model.
    for (int k = 0; k < NI; k++) begin
      mm[k] = init_m[k];
      me[k] = 1'b0;
    end
    for (int c = 0; c < 10000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      en    = ($urandom_range(0, 3) != 0);
      t_req = 10'($urandom);
      for (int k = 0; k < NI; k++) begin
        f = model_fire(mm[k], t_req, en, conc[k]);
        push("rand", k, 5'b11111, f, model_blocked(mm[k], t_req), mm[k], init_t[k], me[k]);
        if (reset) begin
          mm[k] = init_m[k];
          me[k] = 1'b0;
        end else begin
          if (en && ((t_req & ~mm[k]) != 10'h000)) me[k] = 1'b1;
          mm[k] = model_next(mm[k], f);
        end
      end
      step();
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
